// File: rtl/calc_pkg.sv
// Shared definitions for the calculator BCD datapath blocks.
package calc_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // ceil(log2(value)); used to size counters and accumulators at elaboration.
    function automatic int clog2(input longint unsigned value);
        int              n;
        longint unsigned v;
        n = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            n++;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// One decimal accumulation step: y = a*10 + d using shifts and adds only.
module bcd_mul10_add
    import calc_pkg::*;
#(
    parameter int W = 18
) (
    input  logic [W-1:0]           a,
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [W-1:0]           y,
    output logic                   bad
);

    // a*8 + a*2 + digit; non-decimal nibbles still contribute their raw weight
    always_comb begin
        y   = (a << 3) + (a << 1) + W'(d);
        bad = (d > 4'd9);
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first.
//
//  state | meaning
//  IDLE  | waiting for an operand, in_ready high
//  CONV  | consuming one digit per edge; extra edge after the last digit loads the result
//  DONE  | result and flags held with out_valid until out_ready
module bcd_to_binary_seq
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    input  logic                          in_neg,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              bin_out,
    output logic                          err_digit,
    output logic                          ovf
);

    localparam int IN_W  = BCD_DIGIT_W * DIGITS;
    // Sized for all-F input so the accumulator itself never wraps.
    localparam int ACC_W = clog2(16 * pow10(DIGITS));
    localparam int CNT_W = clog2(longint'(DIGITS + 1));
    // One spare bit above both widths so the limit constants never wrap.
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS);
    localparam logic [EXT_W-1:0] ONE      = EXT_W'(1);
    localparam logic [EXT_W-1:0] LIM_U    = (ONE << OUT_W) - ONE;
    localparam logic [EXT_W-1:0] LIM_POS  = (ONE << (OUT_W - 1)) - ONE;
    localparam logic [EXT_W-1:0] LIM_NEG  = ONE << (OUT_W - 1);

    conv_state_t      state;
    logic [IN_W-1:0]  digit_sr;
    logic             neg_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] acc_next;
    logic             nib_bad;
    logic [EXT_W-1:0] acc_ext;
    logic [OUT_W-1:0] trunc;
    logic [OUT_W-1:0] result;
    logic             neg_eff;
    logic             ovf_next;

    bcd_mul10_add #(
        .W (ACC_W)
    ) u_mul10 (
        .a   (acc),
        .d   (digit_sr[IN_W-1 -: BCD_DIGIT_W]),
        .y   (acc_next),
        .bad (nib_bad)
    );

    // Ready is combinational on state so a held source is accepted the first idle cycle.
    always_comb begin
        in_ready = (state == IDLE) && !rst;
    end

    // Final value and range check from the completed accumulator.
    always_comb begin
        neg_eff = (SIGNED != 0) && neg_q;
        acc_ext = EXT_W'(acc);
        trunc   = acc_ext[OUT_W-1:0];
        result  = neg_eff ? ({OUT_W{1'b0}} - trunc) : trunc;
        if (SIGNED == 0) begin
            ovf_next = (acc_ext > LIM_U);
        end else if (neg_eff) begin
            ovf_next = (acc_ext > LIM_NEG);
        end else begin
            ovf_next = (acc_ext > LIM_POS);
        end
    end

    // Control FSM, digit shift register, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            digit_sr  <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            bin_out   <= '0;
            out_valid <= 1'b0;
            err_digit <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        digit_sr  <= bcd_in;
                        neg_q     <= in_neg;
                        acc       <= '0;
                        cnt       <= '0;
                        err_digit <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    if (cnt == CNT_LAST) begin
                        bin_out   <= result;
                        ovf       <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc      <= acc_next;
                        digit_sr <= digit_sr << BCD_DIGIT_W;
                        cnt      <= cnt + CNT_W'(1);
                        if (nib_bad) begin
                            err_digit <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: four configurations checked against an arithmetic model.
module tb_bcd_to_binary_seq;

    localparam int DG [4] = '{4, 4, 6, 1};
    localparam int OW [4] = '{16, 14, 16, 4};
    localparam int SG [4] = '{0, 1, 0, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_neg;
    logic [3:0]  out_ready;
    logic [23:0] bcd_bus;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  err_digit;
    logic [3:0]  ovf_w;
    logic [15:0] bin0;
    logic [13:0] bin1;
    logic [15:0] bin2;
    logic [3:0]  bin3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_to_binary_seq #(.DIGITS(4), .OUT_W(16), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .bcd_in(bcd_bus[15:0]), .in_neg(in_neg[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .bin_out(bin0), .err_digit(err_digit[0]), .ovf(ovf_w[0])
    );
    bcd_to_binary_seq #(.DIGITS(4), .OUT_W(14), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .bcd_in(bcd_bus[15:0]), .in_neg(in_neg[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .bin_out(bin1), .err_digit(err_digit[1]), .ovf(ovf_w[1])
    );
    bcd_to_binary_seq #(.DIGITS(6), .OUT_W(16), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .bcd_in(bcd_bus), .in_neg(in_neg[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .bin_out(bin2), .err_digit(err_digit[2]), .ovf(ovf_w[2])
    );
    bcd_to_binary_seq #(.DIGITS(1), .OUT_W(4), .SIGNED(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .bcd_in(bcd_bus[3:0]), .in_neg(in_neg[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .bin_out(bin3), .err_digit(err_digit[3]), .ovf(ovf_w[3])
    );

    function automatic logic [15:0] get_bin(input int sel);
        case (sel)
            0:       return bin0;
            1:       return {2'b00, bin1};
            2:       return bin2;
            default: return {12'h000, bin3};
        endcase
    endfunction

    // Decimal value as a weighted sum of nibbles, then signed/unsigned range and wrap.
    function automatic void ref_model(input int sel, input logic [23:0] bcd, input logic neg,
                                      output logic [15:0] e_bin, output logic e_err,
                                      output logic e_ovf);
        longint val;
        longint s;
        longint w;
        longint nib;
        longint weight;
        val    = 0;
        weight = 1;
        w      = longint'(OW[sel]);
        e_err  = 1'b0;
        for (int i = 0; i < DG[sel]; i++) begin
            nib = longint'(bcd[4*i +: 4]);
            if (nib > 9) e_err = 1'b1;
            val    = val + nib * weight;
            weight = weight * 10;
        end
        if (SG[sel] != 0 && neg) begin
            s     = -val;
            e_ovf = (s < -(longint'(1) << (w - 1)));
        end else if (SG[sel] != 0) begin
            s     = val;
            e_ovf = (val > (longint'(1) << (w - 1)) - 1);
        end else begin
            s     = val;
            e_ovf = (val > (longint'(1) << w) - 1);
        end
        e_bin = 16'(s & ((longint'(1) << w) - 1));
    endfunction

    // One full transaction on DUT sel; noise keeps in_valid high with other data while busy.
    task automatic run_conv(input int sel, input logic [23:0] bcd, input logic neg,
                            input int hold, input bit noise, input string name);
        int          lat;
        logic [15:0] eb;
        logic        ee;
        logic        eo;
        ref_model(sel, bcd, neg, eb, ee, eo);
        lat = 0;
        while (!in_ready[sel] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (!in_ready[sel]) begin
            fails++;
            $display("FAIL %s ready_timeout in_ready=%0b required 1", name, in_ready[sel]);
            return;
        end
        bcd_bus       = bcd;
        in_neg[sel]   = neg;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (noise) bcd_bus = 24'h999999;
        else in_valid[sel] = 1'b0;
        lat = 0;
        while (!out_valid[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid[sel] = 1'b0;
        tests++;
        if (lat != DG[sel] + 1 || !out_valid[sel]) begin
            fails++;
            $display("FAIL %s latency got %0d required %0d", name, lat, DG[sel] + 1);
        end
        tests++;
        if (get_bin(sel) !== eb) begin
            fails++;
            $display("FAIL %s bin_out got %0d required %0d", name, get_bin(sel), eb);
        end
        tests++;
        if (err_digit[sel] !== ee) begin
            fails++;
            $display("FAIL %s err_digit got %0b required %0b", name, err_digit[sel], ee);
        end
        tests++;
        if (ovf_w[sel] !== eo) begin
            fails++;
            $display("FAIL %s ovf got %0b required %0b", name, ovf_w[sel], eo);
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            tests++;
            if ({out_valid[sel], get_bin(sel), err_digit[sel], ovf_w[sel], in_ready[sel]}
                !== {1'b1, eb, ee, eo, 1'b0}) begin
                fails++;
                $display("FAIL %s hold_cycle%0d ov=%0b bin=%0d err=%0b ovf=%0b rdy=%0b required 1 %0d %0b %0b 0",
                         name, c, out_valid[sel], get_bin(sel), err_digit[sel], ovf_w[sel],
                         in_ready[sel], eb, ee, eo);
            end
        end
        out_ready[sel] = 1'b1;
        @(negedge clk);
        out_ready[sel] = 1'b0;
        tests++;
        if (out_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1) begin
            fails++;
            $display("FAIL %s release ov=%0b rdy=%0b required 0 1", name, out_valid[sel],
                     in_ready[sel]);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_neg    = '0;
        out_ready = '0;
        bcd_bus   = '0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 4'h0) begin
            fails++;
            $display("FAIL reset_in_ready got %b required 0000", in_ready);
        end
        tests++;
        if ({out_valid, err_digit, ovf_w} !== 12'h000 || bin0 !== 16'h0 || bin1 !== 14'h0) begin
            fails++;
            $display("FAIL reset_outputs ov=%b err=%b ovf=%b bin0=%0d bin1=%0d required zeros",
                     out_valid, err_digit, ovf_w, bin0, bin1);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 4'hF) begin
            fails++;
            $display("FAIL reset_release_in_ready got %b required 1111", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_conv(0, 24'h001234, 1'b0, 0, 1'b0, "basic_1234");
        run_conv(0, 24'h009999, 1'b0, 0, 1'b0, "max_9999");
        run_conv(0, 24'h000000, 1'b0, 10, 1'b0, "zero_hold10");
    endtask

    task automatic test_bad_digit();
        run_conv(0, 24'h0012A4, 1'b0, 1, 1'b0, "bad_12A4");
        run_conv(0, 24'h000001, 1'b0, 0, 1'b0, "err_clear_0001");
    endtask

    task automatic test_signed();
        run_conv(1, 24'h008191, 1'b1, 0, 1'b0, "signed_neg8191");
        run_conv(1, 24'h008192, 1'b0, 0, 1'b0, "signed_pos8192_ovf");
        run_conv(1, 24'h008192, 1'b1, 0, 1'b0, "signed_neg8192");
        run_conv(1, 24'h000000, 1'b1, 0, 1'b0, "signed_neg_zero");
        run_conv(0, 24'h000042, 1'b1, 0, 1'b0, "unsigned_neg_ignored");
    endtask

    task automatic test_overflow();
        run_conv(2, 24'h999999, 1'b0, 2, 1'b0, "d6_999999_ovf");
        run_conv(2, 24'h065535, 1'b0, 0, 1'b0, "d6_65535_fit");
        run_conv(2, 24'h065536, 1'b0, 0, 1'b0, "d6_65536_ovf");
    endtask

    task automatic test_digits1();
        run_conv(3, 24'h000009, 1'b0, 0, 1'b0, "d1_9");
        run_conv(3, 24'h00000F, 1'b0, 0, 1'b0, "d1_F");
    endtask

    task automatic test_abort();
        int seen;
        while (!in_ready[0]) @(negedge clk);
        bcd_bus     = 24'h005555;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || bin0 !== 16'h0) begin
            fails++;
            $display("FAIL abort_state rdy=%0b ov=%0b bin=%0d required 1 0 0", in_ready[0],
                     out_valid[0], bin0);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_out_valid got %0d cycles required 0", seen);
        end
        run_conv(0, 24'h000042, 1'b0, 0, 1'b1, "after_abort_0042_busy_valid");
    endtask

    task automatic test_random();
        logic [23:0] b;
        for (int sel = 0; sel < 4; sel++) begin
            for (int n = 0; n < 25; n++) begin
                b = '0;
                for (int i = 0; i < 6; i++) begin
                    if ($urandom_range(0, 7) == 0) b[4*i +: 4] = 4'($urandom_range(10, 15));
                    else b[4*i +: 4] = 4'($urandom_range(0, 9));
                end
                run_conv(sel, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_digit();
        test_signed();
        test_overflow();
        test_digits1();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
